// File: rtl/regfile_write_arbiter_pkg.sv
// Shared pipeline definitions for the register-file write arbiter.
//   arb_state_e   : arbiter FSM encoding (PRIO_A, FORCE_B)
//   DATA_W_DEF    : default write-data width
//   ADDR_W_DEF    : default register-index width
//   CNT_W/CNT_MAX : starvation counter width and saturation value
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] CNT_MAX = 4'hF;

  typedef enum logic {
    PRIO_A  = 1'b0,  // A wins a tie
    FORCE_B = 1'b1   // B has starved; B wins a tie until it transfers
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter in front of the register file.
// A (pipeline writeback) normally wins; B (mul/div writeback) is forced a
// grant once it has waited STARVE_LIMIT consecutive cycles. The winning
// request is registered and drives the register-file write port one cycle
// after the transfer. Writes to register 0 are accepted but dropped.
//   Clock, Reset_n           : clock, async active-low reset
//   A_valid/A_reg/A_data     : A request     A_ready : A accepted this cycle
//   B_valid/B_reg/B_data     : B request     B_ready : B accepted this cycle
//   RegWrite/Write_register/Write_data : registered register-file write port
//   B_forced                 : FSM is in FORCE_B
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              A_valid,
  input  logic [ADDR_W-1:0] A_reg,
  input  logic [DATA_W-1:0] A_data,
  output logic              A_ready,
  input  logic              B_valid,
  input  logic [ADDR_W-1:0] B_reg,
  input  logic [DATA_W-1:0] B_data,
  output logic              B_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  output logic              B_forced
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              a_rdy, b_rdy, xfer;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Grant: depends only on valids and state. Reset_n gates it so nothing is
  // accepted while the block is held in reset.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (Reset_n) begin
      if (state_q == FORCE_B) begin
        b_rdy = B_valid;
        a_rdy = A_valid & ~B_valid;
      end else begin
        a_rdy = A_valid;
        b_rdy = B_valid & ~A_valid;
      end
    end
  end

  assign A_ready  = a_rdy;
  assign B_ready  = b_rdy;
  assign xfer     = a_rdy | b_rdy;
  assign sel_reg  = b_rdy ? B_reg  : A_reg;
  assign sel_data = b_rdy ? B_data : A_data;

  // Starvation counter and FSM. The FSM looks at the next counter value so
  // that B is forced in the cycle right after its STARVE_LIMIT-th lost cycle.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!B_valid || b_rdy)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      PRIO_A:  if (cnt_d >= LIMIT) state_d = FORCE_B;
      FORCE_B: if (b_rdy)          state_d = PRIO_A;
      default: state_d = PRIO_A;
    endcase
  end

  // Write port: index/data follow any transfer; enable suppressed for $zero.
  always_comb begin
    we_d    = xfer && (sel_reg != '0);
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (xfer) begin
      wreg_d  = sel_reg;
      wdata_d = sel_data;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= PRIO_A;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign RegWrite       = we_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;
  assign B_forced       = (state_q == FORCE_B);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              A_valid, B_valid;
  logic [ADDR_W-1:0] A_reg, B_reg;
  logic [DATA_W-1:0] A_data, B_data;
  logic              A_ready, B_ready, RegWrite, B_forced;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;

  int errs = 0;
  int checks = 0;
  logic [DATA_W-1:0] rf7;
  logic [DATA_W-1:0] exp_d;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .A_valid(A_valid), .A_reg(A_reg), .A_data(A_data), .A_ready(A_ready),
    .B_valid(B_valid), .B_reg(B_reg), .B_data(B_data), .B_ready(B_ready),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .B_forced(B_forced)
  );

  always #5 Clock = ~Clock;

  // Register 7 as the register file would see it.
  always @(negedge Clock)
    if (RegWrite && Write_register == 5'd7) rf7 = Write_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    rf7 = '0;
    Reset_n = 1'b0;
    A_valid = 0; A_reg = '0; A_data = '0;
    B_valid = 0; B_reg = '0; B_data = '0;

    // Reset state, grants blocked during reset
    #2;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", Write_register, 0);
    chk("rst_wdata", Write_data, 0);
    chk("rst_bforced", B_forced, 0);
    A_valid = 1; B_valid = 1;
    #1;
    chk("rst_aready", A_ready, 0);
    chk("rst_bready", B_ready, 0);
    A_valid = 0; B_valid = 0;
    cyc();
    Reset_n = 1'b1;
    cyc();

    // Lone A write
    A_valid = 1; A_reg = 5'd3; A_data = 32'h11;
    #1;
    chk("a_alone_ready", A_ready, 1);
    chk("a_alone_bready", B_ready, 0);
    cyc();
    A_valid = 0;
    chk("a_alone_we", RegWrite, 1);
    chk("a_alone_reg", Write_register, 3);
    chk("a_alone_data", Write_data, 32'h11);

    // Idle cycles hold index/data
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("idle_we", RegWrite, 0);
      chk("idle_reg", Write_register, 3);
      chk("idle_data", Write_data, 32'h11);
    end

    // Starvation: A wins 4, B forced on 5th, A again on 6th
    B_valid = 1; B_reg = 5'd2; B_data = 32'hBEEF;
    for (int k = 1; k <= 6; k++) begin
      A_valid = 1; A_reg = 5'd1; A_data = 32'h100 + k;
      #1;
      chk($sformatf("starve%0d_aready", k), A_ready, (k != 5));
      chk($sformatf("starve%0d_bready", k), B_ready, (k == 5));
      chk($sformatf("starve%0d_bforced", k), B_forced, (k == 5));
      exp_d = (k == 5) ? 32'hBEEF : 32'h100 + k;
      cyc();
      chk($sformatf("starve%0d_data", k), Write_data, exp_d);
      chk($sformatf("starve%0d_reg", k), Write_register, (k == 5) ? 2 : 1);
    end
    A_valid = 0; B_valid = 0;
    cyc();

    // B to $zero: accepted but no write
    B_valid = 1; B_reg = 5'd0; B_data = 32'hDEAD;
    #1;
    chk("zero_bready", B_ready, 1);
    cyc();
    B_valid = 0;
    chk("zero_we", RegWrite, 0);
    cyc();

    // Same-register collision: A first, B's value is final
    A_valid = 1; A_reg = 5'd7; A_data = 32'hA;
    B_valid = 1; B_reg = 5'd7; B_data = 32'hB;
    #1;
    chk("coll_aready", A_ready, 1);
    chk("coll_bready", B_ready, 0);
    cyc();
    A_valid = 0;
    chk("coll_first_data", Write_data, 32'hA);
    #1;
    chk("coll_b_ready2", B_ready, 1);
    cyc();
    B_valid = 0;
    chk("coll_second_we", RegWrite, 1);
    chk("coll_second_data", Write_data, 32'hB);
    cyc();
    chk("coll_rf7_final", rf7, 32'hB);

    // Async reset with pending write while in FORCE_B
    B_valid = 1; B_reg = 5'd4; B_data = 32'h44;
    for (int k = 1; k <= 4; k++) begin
      A_valid = 1; A_reg = 5'd5; A_data = 32'h55;
      cyc();
    end
    A_valid = 0;
    chk("pre_rst_we", RegWrite, 1);
    chk("pre_rst_bforced", B_forced, 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_we", RegWrite, 0);
    chk("mid_rst_bforced", B_forced, 0);
    chk("mid_rst_bready", B_ready, 0);
    #4;
    Reset_n = 1'b1;
    // Counter and state restart: A wins 4 cycles again before B is forced
    for (int k = 1; k <= 5; k++) begin
      A_valid = 1; A_reg = 5'd6; A_data = 32'h600 + k;
      #1;
      chk($sformatf("post_rst%0d_aready", k), A_ready, (k != 5));
      chk($sformatf("post_rst%0d_bforced", k), B_forced, (k == 5));
      cyc();
    end
    A_valid = 0; B_valid = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register-index width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive B-waiting cycles before B is forced a grant (legal range 1..15).
REQ-004 Clock  input  1  single clock, all state on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 A_valid  input  1  pipeline writeback request.
REQ-007 A_reg  input  ADDR_W  destination register of A.
REQ-008 A_data  input  DATA_W  write data of A.
REQ-009 A_ready  output  1  A request accepted this cycle.
REQ-010 B_valid / B_reg / B_data  input  1 / ADDR_W / DATA_W  multicycle-unit (mul/div) writeback request.
REQ-011 B_ready  output  1  B request accepted this cycle.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 Write_register  output  ADDR_W  register-file write index.
REQ-014 Write_data  output  DATA_W  register-file write data.
REQ-015 B_forced  output  1  high while the FSM is in FORCE_B.

Function
REQ-016 A transfer SHALL occur on a port in any cycle where its valid and ready are both high; a requester SHALL hold valid, reg and data stable until it is accepted.
REQ-017 At most one of A_ready, B_ready SHALL be high in any cycle; ready SHALL be combinational from valid and FSM state, with no ready-to-valid dependency.
REQ-018 The FSM SHALL have two states: PRIO_A (A wins when both are valid) and FORCE_B (B wins when both are valid).
REQ-019 In either state a lone valid requester SHALL be granted in the same cycle.
REQ-020 A saturating 4-bit starvation counter SHALL increment each cycle in which B_valid is high and B_ready is low, and SHALL clear on any B transfer or when B_valid is low.
REQ-021 PRIO_A -> FORCE_B SHALL occur when the counter reaches STARVE_LIMIT; FORCE_B -> PRIO_A SHALL occur on the cycle after a B transfer.
REQ-022 The accepted request SHALL be registered: RegWrite, Write_register and Write_data SHALL reflect it exactly one cycle after the transfer (latency 1, throughput 1 per cycle).
REQ-023 In a cycle with no transfer, RegWrite SHALL be 0 on the next cycle and Write_register/Write_data SHALL hold their previous values.
REQ-024 A transfer to register 0 SHALL be accepted (ready asserted) but SHALL produce RegWrite=0 on the next cycle, so $zero is never written.
REQ-025 When A and B target the same register in the same cycle, only the winner SHALL be written; the loser's write SHALL land later, so the loser's value is final.
REQ-026 Arithmetic SHALL be unsigned; the counter SHALL saturate at 15 and never wrap.

Reset
REQ-027 While Reset_n is low: state = PRIO_A, counter = 0, RegWrite = 0, Write_register = 0, Write_data = 0, B_forced = 0; A_ready and B_ready SHALL be 0 regardless of valid.
REQ-028 Reset assertion mid-operation SHALL discard the registered pending write (RegWrite=0 immediately, asynchronously); an un-accepted request stays the requester's responsibility.
REQ-029 Deassertion SHALL be synchronized by the integrator; the first grant MAY occur in the first cycle after Reset_n rises.

Structure
REQ-030 The FSM state encoding (PRIO_A, FORCE_B) and the DATA_W/ADDR_W defaults SHALL live in the shared pipeline package.
REQ-031 The block SHALL be a single module with no sub-modules; it drives the existing register-file write port directly (RegWrite, Write_register, Write_data, Clock).

Verification
REQ-032 A_valid=1, A_reg=3, A_data=0x11 alone -> A_ready=1 same cycle; next cycle RegWrite=1, Write_register=3, Write_data=0x11.
REQ-033 A and B valid continuously with STARVE_LIMIT=4 -> A granted 4 cycles, B granted on cycle 5 with B_forced=1, A granted again on cycle 6.
REQ-034 B_valid alone with B_reg=0 -> B_ready=1; next cycle RegWrite=0.
REQ-035 A and B both target reg 7 in the same cycle (A=0xA, B=0xB) -> A written first; reg 7 finally holds 0xB.
REQ-036 Reset_n pulsed low for half a cycle while a registered write is pending -> RegWrite drops to 0 immediately; after release the state is PRIO_A and the counter is 0.
REQ-037 Idle cycles between transfers -> RegWrite=0 with Write_register/Write_data holding their last values.
